// File: rtl/dense_layer_folded_if.sv
// Frame-level handshake bundle for the folded dense layer: input vector in,
// result vector out, each with its own valid/ready pair.
interface dense_layer_folded_if #(
  parameter int WIDTH       = 16,
  parameter int INPUT_SIZE  = 16,
  parameter int OUTPUT_SIZE = 64
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [INPUT_SIZE-1:0][WIDTH-1:0]     in_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [OUTPUT_SIZE-1:0][WIDTH-1:0]    out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dense_layer_folded.sv
// Time-multiplexed fully-connected layer y = act(W*x + b): PAR MAC lanes are
// reused across OUTPUT_SIZE/PAR output groups, one input element per cycle.
module dense_mac_lane #(
  parameter int WIDTH = 16,
  parameter int NFRAC = 10,
  parameter int AW    = 37,
  parameter int RELU  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    mac_en,
  input  logic signed [WIDTH-1:0] bias,
  input  logic signed [WIDTH-1:0] weight,
  input  logic signed [WIDTH-1:0] x,
  output logic        [WIDTH-1:0] result
);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod;
  logic signed [AW-1:0]      acc, prod_ext, bias_ext, sh;

  assign prod     = weight * x;
  assign prod_ext = {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign bias_ext = {{(AW-WIDTH){bias[WIDTH-1]}}, bias} << NFRAC;
  assign sh       = acc >>> NFRAC;

  always_ff @(posedge clk) begin
    if (!reset)      acc <= '0;
    else if (load)   acc <= bias_ext;
    else if (mac_en) acc <= acc + prod_ext;
  end

  always_comb begin
    if (sh > SAT_MAX)      result = {1'b0, {(WIDTH-1){1'b1}}};
    else if (sh < SAT_MIN) result = {1'b1, {(WIDTH-1){1'b0}}};
    else                   result = sh[WIDTH-1:0];
    if (RELU != 0 && result[WIDTH-1]) result = '0;
  end
endmodule

module dense_layer_folded #(
  parameter int WIDTH       = 16,
  parameter int NFRAC       = 10,
  parameter int INPUT_SIZE  = 16,
  parameter int OUTPUT_SIZE = 64,
  parameter int PAR         = 8,
  parameter int RELU        = 1,
  parameter logic signed [WIDTH-1:0] WEIGHTS [OUTPUT_SIZE][INPUT_SIZE] = '{default: '0},
  parameter logic signed [WIDTH-1:0] BIAS    [OUTPUT_SIZE]             = '{default: '0}
) (
  input  logic                 clk,
  input  logic                 reset,
  dense_layer_folded_if.slave  bus,
  output logic [15:0]          frame_count
);
  localparam int NGROUPS = OUTPUT_SIZE / PAR;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int IW      = $clog2(INPUT_SIZE + 1);
  localparam int AW      = 2*WIDTH + $clog2(INPUT_SIZE) + 1;

  if (PAR < 1 || PAR > OUTPUT_SIZE || (OUTPUT_SIZE % PAR) != 0) begin : g_bad_par
    $error("dense_layer_folded: OUTPUT_SIZE must be a multiple of PAR");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state, state_nxt;

  logic [GW-1:0]                     g, pre_g;
  logic [IW-1:0]                     i;
  logic                              in_ready_q, out_valid_q;
  logic [INPUT_SIZE-1:0][WIDTH-1:0]  x_q;
  logic signed [WIDTH-1:0]           x_sel;
  logic [OUTPUT_SIZE-1:0][WIDTH-1:0] out_q;
  logic [PAR-1:0][WIDTH-1:0]         lane_res;
  logic [15:0]                       frame_cnt;
  logic accept, handoff, mac_en, wb, last_wb, load;

  // in_ready in DONE follows out_ready so a waiting frame enters on the handoff edge.
  assign bus.in_ready  = in_ready_q | (out_valid_q & bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign frame_count   = frame_cnt;

  assign accept  = bus.in_valid & bus.in_ready;
  assign handoff = out_valid_q & bus.out_ready;
  assign mac_en  = (state == COMPUTE) && (i != IW'(INPUT_SIZE));
  assign wb      = (state == COMPUTE) && (i == IW'(INPUT_SIZE));
  assign last_wb = wb && (g == GW'(NGROUPS-1));
  assign load    = accept | (wb & ~last_wb);
  assign pre_g   = accept ? '0 : g + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = COMPUTE;
      COMPUTE: if (last_wb) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = bus.in_valid ? COMPUTE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_sel = '0;
    for (int ii = 0; ii < INPUT_SIZE; ii++)
      if (i == IW'(ii)) x_sel = x_q[ii];
  end

  for (genvar p = 0; p < PAR; p++) begin : g_lane
    logic signed [WIDTH-1:0] w_sel, b_sel;

    // Constant weight/bias ROMs addressed by (group, element).
    always_comb begin
      w_sel = '0;
      for (int gg = 0; gg < NGROUPS; gg++)
        for (int ii = 0; ii < INPUT_SIZE; ii++)
          if (g == GW'(gg) && i == IW'(ii)) w_sel = WEIGHTS[gg*PAR+p][ii];
    end

    always_comb begin
      b_sel = '0;
      for (int gg = 0; gg < NGROUPS; gg++)
        if (pre_g == GW'(gg)) b_sel = BIAS[gg*PAR+p];
    end

    dense_mac_lane #(
      .WIDTH(WIDTH), .NFRAC(NFRAC), .AW(AW), .RELU(RELU)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .mac_en (mac_en),
      .bias   (b_sel),
      .weight (w_sel),
      .x      (x_sel),
      .result (lane_res[p])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      g           <= '0;
      i           <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      out_q       <= '0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt == IDLE);
      out_valid_q <= (state_nxt == DONE);
      if (accept) begin
        x_q <= bus.in_data;
        g   <= '0;
        i   <= '0;
      end else if (wb) begin
        i <= '0;
        g <= last_wb ? '0 : g + 1'b1;
      end else if (mac_en) begin
        i <= i + 1'b1;
      end
      if (handoff) frame_cnt <= frame_cnt + 1'b1;
      for (int gg = 0; gg < NGROUPS; gg++)
        for (int p = 0; p < PAR; p++)
          if (wb && g == GW'(gg)) out_q[gg*PAR+p] <= lane_res[p];
    end
  end
endmodule

// File: tb/tb_dense_layer_folded.sv
// Two folded dense layers (identity+ReLU, mixed weights+linear) driven in
// lockstep with shared stimulus and compared against an arithmetic model.
module tb_dense_layer_folded;
  localparam int W = 16, NF = 10, IS = 4, OS = 4, PAR = 2, L = 10;
  typedef logic [IS-1:0][W-1:0] vin_t;
  typedef logic [OS-1:0][W-1:0] vout_t;

  localparam logic signed [W-1:0] W_ID [OS][IS] = '{
    '{16'sd1024, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd0, 16'sd1024, 16'sd0, 16'sd0},
    '{16'sd0, 16'sd0, 16'sd1024, 16'sd0},
    '{16'sd0, 16'sd0, 16'sd0, 16'sd1024}};
  localparam logic signed [W-1:0] B_ID [OS] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
  localparam logic signed [W-1:0] W_LN [OS][IS] = '{
    '{16'sd1024, 16'sd1024, 16'sd1024, 16'sd1024},
    '{16'sd512, 16'sd0, 16'sd0, 16'sd0},
    '{-16'sd300, 16'sd777, 16'sd1500, -16'sd2048},
    '{16'sd0, 16'sd0, 16'sd0, 16'sd0}};
  localparam logic signed [W-1:0] B_LN [OS] = '{16'sd0, 16'sd0, -16'sd517, 16'sd1024};

  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  vin_t in_data = '0;
  logic [15:0] fc0, fc1, exp_cnt0 = 16'd0, exp_cnt1 = 16'd0;
  int n_checks = 0, n_fail = 0;

  dense_layer_folded_if #(.WIDTH(W), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS)) bus0 ();
  dense_layer_folded_if #(.WIDTH(W), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS)) bus1 ();
  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
  assign bus0.in_data = in_data;    assign bus1.in_data = in_data;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

  dense_layer_folded #(.WIDTH(W), .NFRAC(NF), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS),
    .PAR(PAR), .RELU(1), .WEIGHTS(W_ID), .BIAS(B_ID))
    dut0 (.clk(clk), .reset(reset), .bus(bus0), .frame_count(fc0));
  dense_layer_folded #(.WIDTH(W), .NFRAC(NF), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS),
    .PAR(PAR), .RELU(0), .WEIGHTS(W_LN), .BIAS(B_LN))
    dut1 (.clk(clk), .reset(reset), .bus(bus1), .frame_count(fc1));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic vout_t ref_out(input vin_t x, input bit relu_mode);
    vout_t  y;
    longint acc, r;
    for (int o = 0; o < OS; o++) begin
      acc = (relu_mode ? longint'(B_ID[o]) : longint'(B_LN[o])) * 1024;
      for (int k = 0; k < IS; k++)
        acc += (relu_mode ? longint'(W_ID[o][k]) : longint'(W_LN[o][k])) * longint'($signed(x[k]));
      r = acc >>> NF;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      if (relu_mode && r < 0) r = 0;
      y[o] = r[15:0];
    end
    return y;
  endfunction

  function automatic vin_t rand_vec(input bit wide);
    vin_t x;
    for (int k = 0; k < IS; k++)
      x[k] = wide ? 16'($urandom) : 16'($urandom_range(8191, 0)) - 16'd4096;
    return x;
  endfunction

  // Called at the negedge right after an accept edge; checks latency and data.
  task automatic wait_result(input vin_t x, output vout_t o0, output vout_t o1);
    int lat;
    lat = 0;
    while (!bus0.out_valid && lat < 100) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== L) begin n_fail++; $display("FAIL latency: got %0d edges, want %0d", lat, L); end
    o0 = bus0.out_data;
    o1 = bus1.out_data;
    n_checks++;
    if (o0 !== ref_out(x, 1'b1)) begin
      n_fail++; $display("FAIL relu_data: got %h want %h (x=%h)", o0, ref_out(x, 1'b1), x);
    end
    n_checks++;
    if (o1 !== ref_out(x, 1'b0)) begin
      n_fail++; $display("FAIL lin_data: got %h want %h (x=%h)", o1, ref_out(x, 1'b0), x);
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt0++; exp_cnt1++;
    n_checks++;
    if (fc0 !== exp_cnt0 || fc1 !== exp_cnt1) begin
      n_fail++; $display("FAIL frame_count: got %0d/%0d want %0d/%0d", fc0, fc1, exp_cnt0, exp_cnt1);
    end
    n_checks++;
    if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL valid_drop: got %b/%b want 0/0", bus0.out_valid, bus1.out_valid);
    end
  endtask

  task automatic run_frame(input vin_t x, output vout_t o0, output vout_t o1);
    int n;
    n = 0;
    while (!bus0.in_ready && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL accept_wait: in_ready=%b want 1", bus0.in_ready); end
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(x, o0, o1);
    handoff();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0 || bus0.out_data !== '0 || fc0 !== 16'd0 ||
        bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b0 || bus1.out_data !== '0 || fc1 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b/%b vld=%b/%b data=%h/%h cnt=%0d/%0d want all 0",
               bus0.in_ready, bus1.in_ready, bus0.out_valid, bus1.out_valid,
               bus0.out_data, bus1.out_data, fc0, fc1);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: in_ready=%b/%b want 1/1", bus0.in_ready, bus1.in_ready);
    end
  endtask

  task automatic test_basic();
    vin_t x; vout_t o0, o1, e;
    x[0] = 16'd1024; x[1] = -16'sd2048; x[2] = 16'd512; x[3] = 16'd3072;
    e[0] = 16'd1024; e[1] = 16'd0;      e[2] = 16'd512; e[3] = 16'd3072;
    run_frame(x, o0, o1);
    n_checks++;
    if (o0 !== e) begin n_fail++; $display("FAIL basic_identity: got %h want %h", o0, e); end
  endtask

  task automatic test_saturation();
    vin_t x; vout_t o0, o1;
    for (int k = 0; k < IS; k++) x[k] = 16'd31744;
    run_frame(x, o0, o1);
    n_checks++;
    if (o1[0] !== 16'h7fff) begin n_fail++; $display("FAIL sat_pos: got %h want 7fff", o1[0]); end
    for (int k = 0; k < IS; k++) x[k] = -16'sd31744;
    run_frame(x, o0, o1);
    n_checks++;
    if (o1[0] !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %h want 8000", o1[0]); end
    n_checks++;
    if (o0 !== '0) begin n_fail++; $display("FAIL relu_clamp: got %h want 0", o0); end
  endtask

  task automatic test_trunc_bias();
    vin_t x; vout_t o0, o1;
    x = '0;
    x[0] = 16'hffff;
    run_frame(x, o0, o1);
    n_checks++;
    if (o1[1] !== 16'hffff) begin n_fail++; $display("FAIL trunc_neg: got %h want ffff", o1[1]); end
    x = '0;
    run_frame(x, o0, o1);
    n_checks++;
    if (o1[3] !== 16'd1024) begin n_fail++; $display("FAIL bias_only: got %0d want 1024", o1[3]); end
  endtask

  task automatic test_random();
    vout_t o0, o1;
    for (int t = 0; t < 10; t++) run_frame(rand_vec(t[0]), o0, o1);
  endtask

  task automatic test_backpressure();
    vin_t x1, x2; vout_t o0, o1, h0, h1;
    x1 = rand_vec(1'b0);
    x2 = rand_vec(1'b1);
    in_valid = 1'b1; in_data = x1;
    @(negedge clk);
    in_data = x2;
    wait_result(x1, h0, h1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b1 || bus1.out_valid !== 1'b1 ||
          bus0.out_data !== h0 || bus1.out_data !== h1) begin
        n_fail++;
        $display("FAIL stall_hold c=%0d: rdy=%b vld=%b/%b data=%h/%h want 0 1/1 %h/%h", c,
                 bus0.in_ready, bus0.out_valid, bus1.out_valid, bus0.out_data, bus1.out_data, h0, h1);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_follow: in_ready=%b want 1", bus0.in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    exp_cnt0++; exp_cnt1++;
    n_checks++;
    if (fc0 !== exp_cnt0 || fc1 !== exp_cnt1) begin
      n_fail++; $display("FAIL bp_count: got %0d/%0d want %0d/%0d", fc0, fc1, exp_cnt0, exp_cnt1);
    end
    wait_result(x2, o0, o1);
    handoff();
  endtask

  task automatic test_reset_mid();
    vout_t o0, o1;
    in_valid = 1'b1; in_data = rand_vec(1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0 || bus0.out_data !== '0 || fc0 !== 16'd0 ||
          bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b0 || bus1.out_data !== '0 || fc1 !== 16'd0) begin
        n_fail++;
        $display("FAIL mid_reset c=%0d: rdy=%b vld=%b data=%h/%h cnt=%0d/%0d want all 0", c,
                 bus0.in_ready, bus0.out_valid, bus0.out_data, bus1.out_data, fc0, fc1);
      end
    end
    reset = 1'b1;
    exp_cnt0 = 16'd0; exp_cnt1 = 16'd0;
    @(negedge clk);
    n_checks++;
    if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release: in_ready=%b want 1", bus0.in_ready); end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus0.out_valid !== 1'b0 || bus1.out_valid !== 1'b0) begin
        n_checks++; n_fail++;
        $display("FAIL stale_output c=%0d: out_valid=%b/%b want 0/0", c, bus0.out_valid, bus1.out_valid);
      end
    end
    run_frame(rand_vec(1'b0), o0, o1);
  endtask

  task automatic test_wrap();
    vout_t o0, o1;
    force dut0.frame_cnt = 16'hffff;
    @(negedge clk);
    release dut0.frame_cnt;
    exp_cnt0 = 16'hffff;
    run_frame(rand_vec(1'b1), o0, o1);
    n_checks++;
    if (fc0 !== 16'd0) begin n_fail++; $display("FAIL count_wrap: got %0d want 0", fc0); end
    run_frame(rand_vec(1'b0), o0, o1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_trunc_bias();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dense_layer_folded.md
# dense_layer_folded

Time-multiplexed fully-connected layer for the jet-tagging MLP datapath. It computes `y = act(W·x + b)` in signed fixed point, using `PAR` multiply-accumulate lanes that are reused across `OUTPUT_SIZE/PAR` output groups. It adds a valid/ready handshake with backpressure, output saturation and a selectable ReLU/linear mode. It is a drop-in replacement for a fully parallel dense layer followed by a separate ReLU layer in the network top.

## Interface
- `WIDTH`, 16: data, weight and bias word width (signed two's complement).
- `NFRAC`, 10: fractional bits for data, weights and bias.
- `INPUT_SIZE`, 16: input vector length.
- `OUTPUT_SIZE`, 64: output vector length; must be divisible by `PAR`, otherwise an elaboration `$error`.
- `PAR`, 8: number of parallel MAC lanes, 1..`OUTPUT_SIZE`.
- `RELU`, 1: 1 applies ReLU after saturation; 0 gives linear output.
- `WEIGHTS`, all 0: signed `[WIDTH-1:0]` array indexed `[OUTPUT_SIZE][INPUT_SIZE]`, taken from the layer package.
- `BIAS`, all 0: signed `[WIDTH-1:0]` array indexed `[OUTPUT_SIZE]`, taken from the layer package.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: the block can accept a frame.
- `in_data`, in, `INPUT_SIZE` x `WIDTH` signed: input vector.
- `out_valid`, out, 1: `out_data` holds a complete result.
- `out_ready`, in, 1: the consumer accepts the result.
- `out_data`, out, `OUTPUT_SIZE` x `WIDTH` signed: result vector.
- `frame_count`, out, 16: number of completed handoffs; wraps at 65535 -> 0.

## Operation
- States: IDLE, COMPUTE, DONE.
  - IDLE: `in_ready=1`. On accept (`in_valid & in_ready`), latch `in_data` into the input register bank and go to COMPUTE with group index g=0 and element index i=0.
  - COMPUTE: `in_ready=0`. Each group g covers outputs `g*PAR .. g*PAR+PAR-1` and takes `INPUT_SIZE+1` cycles.
    - MAC phase (`INPUT_SIZE` cycles): lane p does `acc[p] += WEIGHTS[g*PAR+p][i] * x[i]`, with i = 0..`INPUT_SIZE`-1.
    - Writeback (1 cycle): the `PAR` results go to `out_data[g*PAR+p]`.
    - Accumulators are preloaded with `BIAS[...] <<< NFRAC` at the start of each group.
  - After the last group's writeback, go to DONE and set `out_valid=1`.
  - DONE: `out_valid=1`, and `out_data` is held stable. On `out_ready=1`, increment `frame_count` and clear `out_valid`.
    - If `in_valid=1` in the same cycle, that frame is accepted (`in_ready = out_ready` in DONE) and the state goes directly to COMPUTE.
    - Otherwise the state goes to IDLE.
- Arithmetic:
  - The product is `2*WIDTH` bits.
  - The accumulator is `2*WIDTH + clog2(INPUT_SIZE) + 1` bits and never overflows.
  - The result is `acc >>> NFRAC` (arithmetic shift, truncation toward -inf), then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If `RELU=1`, negative results are forced to 0.
- `out_data` entries of groups not yet written in the current frame keep their previous-frame values. Consumers use only `out_data` qualified by `out_valid`.
- Reset (low) at any time:
  - state -> IDLE; `in_ready=0`, `out_valid=0`, `out_data` all 0, `frame_count=0`, accumulators and indices 0.
  - A frame in progress is discarded, with no partial output.
  - `in_ready` goes to 1 on the first cycle after reset is released.

## Timing
- Accept edge = edge 0. `out_valid` rises after edge `L = (OUTPUT_SIZE/PAR)*(INPUT_SIZE+1)`; L = 136 for the defaults.
- Output handoff occurs on an edge with `out_valid & out_ready`. `out_valid` drops after that edge unless a new result is completing, which cannot happen in the same cycle.
- With back-to-back handoff, throughput is one frame per `L+1` cycles; otherwise `L+2` cycles minimum.
- `in_ready` and `out_valid` are registered state decodes. `in_ready` in DONE is combinational from `out_ready`.
- No combinational path from `in_valid` to any output.

## Test plan
1. Basic: `INPUT_SIZE=4`, `OUTPUT_SIZE=4`, `PAR=2`, identity weights (1024 on the diagonal), bias 0, `RELU=1`. Input [1024, -2048, 512, 3072] -> `out_data` [1024, 0, 512, 3072]; `out_valid` rises after edge 10; `frame_count` = 1 after handoff.
2. Saturation: same config, all weights 1024, `RELU=0`. Input all 31744 -> every output 32767. Input all -31744 -> every output -32768.
3. Truncation and bias: weight 512, input -1, bias 0, `RELU=0` -> output -1. Bias 1024 with input 0 -> output 1024.
4. Backpressure: hold `out_ready=0` for 20 cycles after `out_valid` with `in_valid=1`.
   - `out_data` stays stable, `in_ready=0`, and no frame is accepted.
   - Raising `out_ready` accepts the waiting frame on the same edge; its result arrives 10 edges later.
5. Reset mid-compute: drive `reset` low on edge 5 of a frame.
   - `out_valid=0`, `out_data=0`, `frame_count=0`, and `in_ready=0` while reset is low.
   - `in_ready=1` on the cycle after release.
   - No stale output appears; the next frame's result is correct.
6. Counter wrap: preload 65535 handoffs (forced or long run); the next handoff gives `frame_count=0`.
